multi_channel_queue: RTL and testbench

- NUM_CH independent circular FIFOs with separate storage, behind one shared, registered dequeue port.
- Each channel enqueues independently every cycle; one channel is dequeued per cycle, selected by index.
- Sits between per-lane producers and a single arbiter/consumer.
- Adds per-channel occupancy, almost-full, same-cycle enqueue+dequeue on a full channel, and valid-qualified output.

---
 rtl/mcq_pkg.sv | 19 +
 rtl/mcq_channel.sv | 45 ++++
 rtl/multi_channel_queue.sv | 94 +++++++++
 tb/tb_multi_channel_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mcq_pkg.sv
// mcq_pkg: sizing helpers and per-channel status type shared by multi_channel_queue
// Contents: ch_w(n) = channel index width, cnt_w(d) = occupancy width,
//           mcq_status_t = {empty, full, almost_full, count}.
// count is carried at a fixed maximum width; consumers truncate it to cnt_w(DEPTH).
package mcq_pkg;
  localparam int MAX_CNT_W = 16;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction
  typedef struct packed {
    logic                 empty;
    logic                 full;
    logic                 almost_full;
    logic [MAX_CNT_W-1:0] count;
  } mcq_status_t;
endpackage

// File: rtl/mcq_channel.sv
// mcq_channel: one circular FIFO channel (storage, pointers, occupancy count)
// Ports: clk, rst (sync, active-high); wr_en/wr_data write at wr_ptr;
//        rd_en pops at rd_ptr; rd_data = entry at rd_ptr (combinational);
//        status = {empty, full, almost_full, count} from the registered count.
// The caller gates wr_en/rd_en, so this block never checks for overflow/underflow itself.
module mcq_channel
  import mcq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output mcq_status_t      status
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_cnt <= r_cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  // Read is combinational from the pre-edge pointer, so a same-cycle write into
  // the slot being freed on a full channel cannot disturb the popped entry.
  assign rd_data = r_mem[r_rd_ptr];
  assign status  = '{empty:       r_cnt == '0,
                     full:        r_cnt == CNT_W'(DEPTH),
                     almost_full: r_cnt >= CNT_W'(AF_THRESH),
                     count:       MAX_CNT_W'(r_cnt)};
endmodule

// File: rtl/multi_channel_queue.sv
// multi_channel_queue: NUM_CH independent FIFOs behind one registered dequeue port
// Ports: clk, rst (sync, active-high); enq_valid/enq_data/enq_ready per channel;
//        deq_req + deq_ch select one channel per cycle, result on deq_valid/deq_data
//        one cycle later; empty/full/almost_full/count are per-channel status.
// Optional: define MCQ_ERR_EN to add sticky err_ovf[NUM_CH], err_udf[NUM_CH], err_bad_ch.
module multi_channel_queue
  import mcq_pkg::*;
#(
  parameter int  WIDTH     = 32,
  parameter int  DEPTH     = 8,
  parameter int  NUM_CH    = 4,
  parameter int  AF_THRESH = DEPTH - 2,
  localparam int CH_W      = ch_w(NUM_CH),
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enq_valid,
  input  logic [NUM_CH*WIDTH-1:0] enq_data,
  output logic [NUM_CH-1:0]       enq_ready,
  input  logic                    deq_req,
  input  logic [CH_W-1:0]         deq_ch,
  output logic                    deq_valid,
  output logic [WIDTH-1:0]        deq_data,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH*CNT_W-1:0] count
`ifdef MCQ_ERR_EN
  ,
  output logic [NUM_CH-1:0]       err_ovf,
  output logic [NUM_CH-1:0]       err_udf,
  output logic                    err_bad_ch
`endif
);
  mcq_status_t       w_st      [NUM_CH];
  logic [WIDTH-1:0]  w_rd_data [NUM_CH];
  logic [NUM_CH-1:0] w_sel, w_rd_en, w_wr_en;
  logic [WIDTH-1:0]  w_deq_mux;
  logic              r_deq_valid;
  logic [WIDTH-1:0]  r_deq_data;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // An out-of-range deq_ch matches no channel, so it is rejected without indexing.
    assign w_sel[i]       = deq_ch == CH_W'(i);
    assign w_rd_en[i]     = deq_req && w_sel[i] && !w_st[i].empty;
    assign enq_ready[i]   = !w_st[i].full || w_rd_en[i];
    assign w_wr_en[i]     = enq_valid[i] && enq_ready[i];
    assign empty[i]       = w_st[i].empty;
    assign full[i]        = w_st[i].full;
    assign almost_full[i] = w_st[i].almost_full;
    assign count[i*CNT_W +: CNT_W] = CNT_W'(w_st[i].count);
    mcq_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_en[i]),
      .wr_data (enq_data[i*WIDTH +: WIDTH]),
      .rd_en   (w_rd_en[i]),
      .rd_data (w_rd_data[i]),
      .status  (w_st[i])
    );
  end
  // At most one w_rd_en bit is set, so an AND-OR mux suffices.
  always_comb begin
    w_deq_mux = '0;
    for (int k = 0; k < NUM_CH; k++) w_deq_mux = w_deq_mux | (w_rd_en[k] ? w_rd_data[k] : '0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_deq_valid <= 1'b0;
      r_deq_data  <= '0;
    end else begin
      r_deq_valid <= |w_rd_en;
      if (|w_rd_en) r_deq_data <= w_deq_mux;
    end
  assign deq_valid = r_deq_valid;
  assign deq_data  = r_deq_data;
`ifdef MCQ_ERR_EN
  logic [NUM_CH-1:0] r_err_ovf, r_err_udf;
  logic              r_err_bad_ch;
  always_ff @(posedge clk)
    if (rst) begin
      r_err_ovf    <= '0;
      r_err_udf    <= '0;
      r_err_bad_ch <= 1'b0;
    end else begin
      r_err_ovf    <= r_err_ovf | (enq_valid & ~enq_ready);
      r_err_udf    <= r_err_udf | ({NUM_CH{deq_req}} & w_sel & empty);
      r_err_bad_ch <= r_err_bad_ch | (deq_req && !(|w_sel));
    end
  assign err_ovf    = r_err_ovf;
  assign err_udf    = r_err_udf;
  assign err_bad_ch = r_err_bad_ch;
`endif
endmodule

// File: tb/tb_multi_channel_queue.sv
// tb_multi_channel_queue: directed + random check of multi_channel_queue against a queue-based model
module tb_multi_channel_queue;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   enq_valid, enq_ready, empty, full, almost_full;
  logic [127:0] enq_data;
  logic         deq_req, deq_valid;
  logic [1:0]   deq_ch;
  logic [31:0]  deq_data;
  logic [15:0]  count;
  logic [2:0]   b_enq_valid, b_enq_ready, b_empty, b_full, b_almost_full;
  logic [95:0]  b_enq_data;
  logic         b_deq_req, b_deq_valid;
  logic [1:0]   b_deq_ch;
  logic [31:0]  b_deq_data;
  logic [11:0]  b_count;
`ifdef MCQ_ERR_EN
  logic [3:0]   err_ovf, err_udf;
  logic         err_bad_ch;
  logic [2:0]   b_err_ovf, b_err_udf;
  logic         b_err_bad_ch;
`endif
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [31:0]  mq [4][$];
  logic         m_valid;
  logic [31:0]  m_data;

  always #5 clk = ~clk;

  multi_channel_queue dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_req(deq_req), .deq_ch(deq_ch), .deq_valid(deq_valid), .deq_data(deq_data),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count)
`ifdef MCQ_ERR_EN
    , .err_ovf(err_ovf), .err_udf(err_udf), .err_bad_ch(err_bad_ch)
`endif
  );

  // Three channels leave deq_ch = 3 representable but out of range.
  multi_channel_queue #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .enq_valid(b_enq_valid), .enq_data(b_enq_data), .enq_ready(b_enq_ready),
    .deq_req(b_deq_req), .deq_ch(b_deq_ch), .deq_valid(b_deq_valid), .deq_data(b_deq_data),
    .empty(b_empty), .full(b_full), .almost_full(b_almost_full), .count(b_count)
`ifdef MCQ_ERR_EN
    , .err_ovf(b_err_ovf), .err_udf(b_err_udf), .err_bad_ch(b_err_bad_ch)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] at(input int ch, input logic [31:0] d);
    return 128'(d) << (ch * 32);
  endfunction

  task automatic check_state();
    int sz;
    chk("deq_valid", 64'(deq_valid), 64'(m_valid));
    chk("deq_data", 64'(deq_data), 64'(m_data));
    for (int i = 0; i < 4; i++) begin
      sz = mq[i].size();
      chk($sformatf("count%0d", i), 64'(count[i*4 +: 4]), 64'(sz));
      chk($sformatf("empty%0d", i), 64'(empty[i]), 64'(sz == 0));
      chk($sformatf("full%0d", i), 64'(full[i]), 64'(sz == DEPTH));
      chk($sformatf("afull%0d", i), 64'(almost_full[i]), 64'(sz >= AF));
    end
  endtask

  // One clock of stimulus: check combinational enq_ready, advance the model, check post-edge state.
  task automatic cyc(input logic [3:0] ev, input logic [127:0] ed, input logic dr, input logic [1:0] dc);
    logic       acc;
    logic [3:0] rdy;
    @(negedge clk);
    enq_valid = ev;
    enq_data  = ed;
    deq_req   = dr;
    deq_ch    = dc;
    #1;
    acc = dr && mq[dc].size() > 0;
    for (int i = 0; i < 4; i++) begin
      rdy[i] = mq[i].size() < DEPTH || (acc && dc == 2'(i));
      chk($sformatf("enq_ready%0d", i), 64'(enq_ready[i]), 64'(rdy[i]));
    end
    m_valid = acc;
    if (acc) m_data = mq[dc].pop_front();
    for (int i = 0; i < 4; i++)
      if (ev[i] && rdy[i]) mq[i].push_back(ed[i*32 +: 32]);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_rst(input logic [3:0] ev, input logic dr);
    @(negedge clk);
    rst       = 1'b1;
    enq_valid = ev;
    enq_data  = {$urandom, $urandom, $urandom, $urandom};
    deq_req   = dr;
    deq_ch    = 2'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data  = '0;
    check_state();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enq_valid = '0; enq_data = '0; deq_req = 1'b0; deq_ch = '0;
    b_enq_valid = '0; b_enq_data = '0; b_deq_req = 1'b0; b_deq_ch = '0;
    m_valid = 1'b0; m_data = '0;
    do_rst(4'b0000, 1'b0);
    chk("rst_enq_ready", 64'(enq_ready), 64'hF);
    chk("rst_empty", 64'(empty), 64'hF);
    // ch2 in-order traffic
    cyc(4'b0100, at(2, 32'hA1), 1'b0, 2'd0);
    cyc(4'b0100, at(2, 32'hA2), 1'b0, 2'd0);
    cyc(4'b0100, at(2, 32'hA3), 1'b0, 2'd0);
    cyc(4'b0000, '0, 1'b1, 2'd2);
    chk("ch2_first", 64'(deq_data), 64'hA1);
    cyc(4'b0000, '0, 1'b1, 2'd2);
    cyc(4'b0000, '0, 1'b1, 2'd2);
    chk("ch2_last", 64'(deq_data), 64'hA3);
    chk("ch2_empty", 64'(empty[2]), 64'd1);
    // fill ch0, then overflow attempt
    for (int k = 0; k < DEPTH; k++) cyc(4'b0001, at(0, 32'h100 + 32'(k)), 1'b0, 2'd0);
    chk("ch0_full", 64'(full[0]), 64'd1);
    cyc(4'b0001, at(0, 32'h1FF), 1'b0, 2'd0);
    chk("ch0_ovf_count", 64'(count[3:0]), 64'd8);
`ifdef MCQ_ERR_EN
    chk("err_ovf0", 64'(err_ovf[0]), 64'd1);
`endif
    // full channel: enqueue and dequeue together
    cyc(4'b0001, at(0, 32'h55), 1'b1, 2'd0);
    chk("full_swap_data", 64'(deq_data), 64'h100);
    chk("full_swap_count", 64'(count[3:0]), 64'd8);
    for (int k = 0; k < DEPTH; k++) cyc(4'b0000, '0, 1'b1, 2'd0);
    chk("full_swap_last", 64'(deq_data), 64'h55);
    // empty channel: no bypass
    cyc(4'b0010, at(1, 32'h77), 1'b1, 2'd1);
    chk("nobypass_valid", 64'(deq_valid), 64'd0);
    chk("nobypass_count", 64'(count[7:4]), 64'd1);
`ifdef MCQ_ERR_EN
    chk("err_udf1", 64'(err_udf[1]), 64'd1);
`endif
    cyc(4'b0000, '0, 1'b1, 2'd1);
    chk("nobypass_data", 64'(deq_data), 64'h77);
    // ch3 steady-state wrap-around
    cyc(4'b1000, at(3, 32'h200), 1'b0, 2'd0);
    cyc(4'b1000, at(3, 32'h201), 1'b0, 2'd0);
    for (int k = 0; k < 20; k++) cyc(4'b1000, at(3, 32'h202 + 32'(k)), 1'b1, 2'd3);
    chk("wrap_last", 64'(deq_data), 64'h213);
    chk("wrap_count", 64'(count[15:12]), 64'd2);
    // random traffic
    for (int k = 0; k < 400; k++)
      cyc(4'($urandom), {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) != 0, 2'($urandom));
    // reset mid-stream with requests pending
    do_rst(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) cyc(4'b0001, at(0, 32'h300 + 32'(k)), 1'b0, 2'd0);
    chk("pre_rst_count", 64'(count[3:0]), 64'd5);
    do_rst(4'b1111, 1'b1);
    chk("rst_counts", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_data", 64'(deq_data), 64'd0);
    // out-of-range channel on the 3-channel instance
    @(negedge clk);
    b_enq_valid = 3'b001;
    b_enq_data  = 96'h33;
    @(posedge clk);
    #1;
    @(negedge clk);
    b_enq_valid = '0;
    b_deq_req   = 1'b1;
    b_deq_ch    = 2'd3;
    @(posedge clk);
    #1;
    chk("bad_ch_valid", 64'(b_deq_valid), 64'd0);
    chk("bad_ch_count", 64'(b_count[3:0]), 64'd1);
    chk("bad_ch_data", 64'(b_deq_data), 64'd0);
`ifdef MCQ_ERR_EN
    chk("err_bad_ch", 64'(b_err_bad_ch), 64'd1);
`endif
    @(negedge clk);
    b_deq_ch = 2'd0;
    @(posedge clk);
    #1;
    chk("b_deq_valid", 64'(b_deq_valid), 64'd1);
    chk("b_deq_data", 64'(b_deq_data), 64'h33);
    b_deq_req = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
